// File: rtl/seq_restoring_divider.sv
// Iterative radix-2 restoring divider: 2W-bit unsigned dividend / W-bit divisor, one quotient bit per cycle.
// Optional result self-check (quotient*divisor+remainder == dividend) enabled by defining DIV_SELFCHECK_EN.
module seq_restoring_divider #(
  parameter int W = 16
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow,
  output logic           check_err,
  output logic [1:0]     dbg_state
);

  // Handshake: a transfer happens on a posedge where valid && ready are both high;
  // in_valid is sampled only in IDLE and out_ready only while out_valid is high in DONE.
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_DONE} state_e;

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_e         state_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic [2*W-1:0] dvd_q;
  logic [W-1:0]   dvs_q;
  logic [W-1:0]   rem_q;
  logic [W-1:0]   sreg_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   quotient_q;
  logic [W-1:0]   remainder_q;
  logic           div_by_zero_q;
  logic           overflow_q;

  logic [W:0]     trial_w;
  logic [W-1:0]   diff_w;
  logic           ge_w;
  logic [W-1:0]   rem_d;
  logic [W-1:0]   sreg_d;

  // Partial remainder stays below the divisor, so the low W bits of the difference are exact.
  always_comb begin
    trial_w = {rem_q, sreg_q[W-1]};
    diff_w  = trial_w[W-1:0] - dvs_q;
    ge_w    = (trial_w >= {1'b0, dvs_q});
    rem_d   = ge_w ? diff_w : trial_w[W-1:0];
    sreg_d  = {sreg_q[W-2:0], ge_w};
  end

`ifdef DIV_SELFCHECK_EN
  logic           check_err_q;
  logic [2*W-1:0] prod_w;
  logic           mismatch_w;

  always_comb begin
    prod_w     = ({{W{1'b0}}, quotient_q} * {{W{1'b0}}, dvs_q}) + {{W{1'b0}}, remainder_q};
    mismatch_w = !overflow_q && (prod_w != dvd_q);
  end

  assign check_err = check_err_q;
`else
  assign check_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      dvd_q         <= '0;
      dvs_q         <= '0;
      rem_q         <= '0;
      sreg_q        <= '0;
      cnt_q         <= '0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
`ifdef DIV_SELFCHECK_EN
      check_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            dvd_q         <= dividend;
            dvs_q         <= divisor;
            in_ready_q    <= 1'b0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
            state_q       <= S_CHECK;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        S_CHECK: begin
          if (dvs_q == '0) begin
            div_by_zero_q <= 1'b1;
            overflow_q    <= 1'b1;
            quotient_q    <= '1;
            remainder_q   <= dvd_q[W-1:0];
            state_q       <= S_DONE;
          end else if (dvd_q[2*W-1:W] >= dvs_q) begin
            overflow_q  <= 1'b1;
            quotient_q  <= '1;
            remainder_q <= '0;
            state_q     <= S_DONE;
          end else begin
            rem_q   <= dvd_q[2*W-1:W];
            sreg_q  <= dvd_q[W-1:0];
            cnt_q   <= CW'(W - 1);
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          rem_q  <= rem_d;
          sreg_q <= sreg_d;
          if (cnt_q == '0) begin
            quotient_q  <= sreg_d;
            remainder_q <= rem_d;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          // First DONE cycle settles the result (and the self-check); out_valid rises after it.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
`ifdef DIV_SELFCHECK_EN
            check_err_q <= mismatch_w;
`endif
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
`ifdef DIV_SELFCHECK_EN
            check_err_q <= 1'b0;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign overflow    = overflow_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider: hand-computed vectors, expected queue, latency and hold checks.
module tb_seq_restoring_divider;

  localparam int W = 16;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;
  logic           check_err;
  logic [1:0]     dbg_state;

  int checks   = 0;
  int failures = 0;

  // Expected entry: {overflow, div_by_zero, quotient, remainder}
  logic [2*W+1:0] exp_q[$];

  seq_restoring_divider #(.W(W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .check_err   (check_err),
    .dbg_state   (dbg_state)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [2*W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check_eq("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    dividend = $urandom_range(0, 32'hFFFF);
    divisor  = W'($urandom_range(0, 16'hFFFF));
  endtask

  task automatic collect(input string tag, input int exp_lat, input int hold);
    int n = 0;
    logic [2*W+1:0] e;
    while (!out_valid && n < 100) begin
      @(posedge clock);
      n++;
      @(negedge clock);
    end
    check_eq({tag, "_latency"}, n, exp_lat);
    e = exp_q.pop_front();
    check_eq({tag, "_quotient"}, quotient, e[2*W-1:W]);
    check_eq({tag, "_remainder"}, remainder, e[W-1:0]);
    check_eq({tag, "_div_by_zero"}, div_by_zero, e[2*W]);
    check_eq({tag, "_overflow"}, overflow, e[2*W+1]);
    check_eq({tag, "_check_err"}, check_err, 0);
    check_eq({tag, "_in_ready_busy"}, in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check_eq({tag, "_hold_valid"}, out_valid, 1);
      check_eq({tag, "_hold_quotient"}, quotient, e[2*W-1:W]);
      check_eq({tag, "_hold_remainder"}, remainder, e[W-1:0]);
      check_eq({tag, "_hold_in_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    check_eq({tag, "_valid_dropped"}, out_valid, 0);
    check_eq({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [2*W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] q, input logic [W-1:0] r, input logic dz,
                        input logic ovf, input int lat, input int hold);
    exp_q.push_back({ovf, dz, q, r});
    send(a, b);
    collect(tag, lat, hold);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clock);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_quotient", quotient, 0);
    check_eq("rst_remainder", remainder, 0);
    check_eq("rst_flags", {div_by_zero, overflow, check_err}, 0);
    reset_n = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_eq("rst_in_ready_release", in_ready, 1);

    run_op("t1_1000_7",   32'd1000,       16'd7,      16'd142,   16'd6,      1'b0, 1'b0, 18, 0);
    run_op("t2_ffff_1",   32'h0000_FFFF,  16'h0001,   16'hFFFF,  16'h0000,   1'b0, 1'b0, 18, 0);
    run_op("t3_div0",     32'h1234_5678,  16'h0000,   16'hFFFF,  16'h5678,   1'b1, 1'b1, 2,  0);
    run_op("t4_ovf",      32'h0005_0000,  16'h0005,   16'hFFFF,  16'h0000,   1'b0, 1'b1, 2,  0);
    run_op("t5_hold",     32'd1000,       16'd7,      16'd142,   16'd6,      1'b0, 1'b0, 18, 5);
    run_op("t5_max",      32'hFFFE_0001,  16'hFFFF,   16'hFFFF,  16'h0000,   1'b0, 1'b0, 18, 0);
    run_op("x_half",      32'h7FFF_FFFF,  16'h8000,   16'hFFFF,  16'h7FFF,   1'b0, 1'b0, 18, 0);
    run_op("x_zero_dvd",  32'd0,          16'd5,      16'd0,     16'd0,      1'b0, 1'b0, 18, 0);
    run_op("x_mixed",     32'd123456,     16'd1000,   16'd123,   16'd456,    1'b0, 1'b0, 18, 0);

    // Reset in the middle of RUN discards the operation
    send(32'd1000, 16'd7);
    repeat (9) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t6_rst_out_valid", out_valid, 0);
    check_eq("t6_rst_in_ready", in_ready, 0);
    check_eq("t6_rst_quotient", quotient, 0);
    check_eq("t6_rst_remainder", remainder, 0);
    check_eq("t6_rst_flags", {div_by_zero, overflow, check_err}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_eq("t6_in_ready_release", in_ready, 1);
    check_eq("t6_no_stale_valid", out_valid, 0);
    run_op("t6_100_10",   32'd100,        16'd10,     16'd10,    16'd0,      1'b0, 1'b0, 18, 0);

    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
